// File: rtl/guitar_effect.sv
// Avalon-MM distortion effect: a gain -> hard clip -> boost pipeline with
// saturation, triggered by the synchronized rising edge of the clk_500 strobe.
module guitar_effect #(
  parameter int CLIP_LEVEL = 8192,
  parameter int SAMPLE_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_500,
  input  logic [4:0]  avl_address,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  output logic [31:0] avl_readdata,
  output logic        avl_read
);

  localparam logic [4:0] ADDR_GAIN   = 5'd1;
  localparam logic [4:0] ADDR_BOOST  = 5'd2;
  localparam logic [4:0] ADDR_STATUS = 5'd3;
  localparam logic [4:0] ADDR_OUTPUT = 5'd5;
  localparam logic [4:0] ADDR_INPUT  = 5'd6;

  localparam int PROD_W  = SAMPLE_W + 9;
  localparam int BOOST_W = PROD_W + 9;
  localparam int EXT_W   = 32 - SAMPLE_W;

  localparam logic signed [PROD_W-1:0]  CLIP_POS = PROD_W'(CLIP_LEVEL);
  localparam logic signed [PROD_W-1:0]  CLIP_NEG = -CLIP_POS;
  localparam logic signed [BOOST_W-1:0] SAT_MAX  = BOOST_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [BOOST_W-1:0] SAT_MIN  = -SAT_MAX - BOOST_W'(1);

  // Control / data registers
  logic [7:0]                 gain_q, gain_d;
  logic [7:0]                 boost_q, boost_d;
  logic                       enable_q, enable_d;
  logic                       clipped_q, clipped_d;
  logic signed [SAMPLE_W-1:0] input_q, input_d;
  logic signed [SAMPLE_W-1:0] output_q, output_d;

  // Strobe synchronizer and pipeline
  logic                       sync1_q, sync2_q, sync3_q;
  logic                       tick;
  logic signed [SAMPLE_W-1:0] x_q, x1_q;
  logic                       v0_q, v1_q;
  logic signed [PROD_W-1:0]   p_q, p_d;
  logic                       read_q, read_d;

  // Datapath temporaries
  logic signed [PROD_W-1:0]   x_ext, gain_ext, clamped;
  logic signed [BOOST_W-1:0]  c_ext, boost_ext, boosted, saturated;
  logic                       over_clip;

  assign tick = sync2_q & ~sync3_q;

  // Stage 1: exact signed product; GAIN is zero-extended so it stays positive.
  always_comb begin
    x_ext    = PROD_W'(x_q);
    gain_ext = PROD_W'({1'b0, gain_q});
    p_d      = x_ext * gain_ext;
  end

  // Stage 2: clamp, boost, saturate to the sample range.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    clamped   = p_q;
    over_clip = 1'b0;
    if (p_q > CLIP_POS) begin
      clamped   = CLIP_POS;
      over_clip = 1'b1;
    end else if (p_q < CLIP_NEG) begin
      clamped   = CLIP_NEG;
      over_clip = 1'b1;
    end
    c_ext     = BOOST_W'(clamped);
    boost_ext = BOOST_W'({1'b0, boost_q});
    boosted   = c_ext * boost_ext;
    saturated = boosted;
    if (boosted > SAT_MAX) begin
      saturated = SAT_MAX;
    end else if (boosted < SAT_MIN) begin
      saturated = SAT_MIN;
    end
  end

  // Register file writes and pipeline result; a clip event in the same cycle
  // as a software clear wins so the event is never lost.
  always_comb begin
    gain_d    = gain_q;
    boost_d   = boost_q;
    enable_d  = enable_q;
    clipped_d = clipped_q;
    input_d   = input_q;
    output_d  = output_q;
    read_d    = v1_q;

    if (avl_write) begin
      unique case (avl_address)
        ADDR_GAIN:   gain_d  = avl_writedata[7:0];
        ADDR_BOOST:  boost_d = avl_writedata[7:0];
        ADDR_STATUS: begin
          enable_d = avl_writedata[0];
          if (avl_writedata[1]) clipped_d = 1'b0;
        end
        ADDR_INPUT:  input_d = avl_writedata[SAMPLE_W-1:0];
        default:     ;
      endcase
    end

    if (v1_q) begin
      if (enable_q) begin
        output_d = saturated[SAMPLE_W-1:0];
        if (over_clip) clipped_d = 1'b1;
      end else begin
        output_d = x1_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gain_q    <= 8'd1;
      boost_q   <= 8'd1;
      enable_q  <= 1'b1;
      clipped_q <= 1'b0;
      input_q   <= '0;
      output_q  <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      x_q       <= '0;
      x1_q      <= '0;
      p_q       <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      read_q    <= 1'b0;
    end else begin
      gain_q    <= gain_d;
      boost_q   <= boost_d;
      enable_q  <= enable_d;
      clipped_q <= clipped_d;
      input_q   <= input_d;
      output_q  <= output_d;
      sync1_q   <= clk_500;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      if (tick) x_q <= input_q;
      v0_q      <= tick;
      p_q       <= p_d;
      x1_q      <= x_q;
      v1_q      <= v0_q;
      read_q    <= read_d;
    end
  end

  always_comb begin
    avl_readdata = '0;
    unique case (avl_address)
      ADDR_GAIN:   avl_readdata = {24'd0, gain_q};
      ADDR_BOOST:  avl_readdata = {24'd0, boost_q};
      ADDR_STATUS: avl_readdata = {30'd0, clipped_q, enable_q};
      ADDR_OUTPUT: avl_readdata = {{EXT_W{output_q[SAMPLE_W-1]}}, output_q};
      ADDR_INPUT:  avl_readdata = {{EXT_W{input_q[SAMPLE_W-1]}}, input_q};
      default:     avl_readdata = '0;
    endcase
  end

  assign avl_read = read_q;

endmodule

// File: tb/tb_guitar_effect.sv
// Directed bench for guitar_effect: register access, pipeline latency,
// clipping/saturation boundaries, bypass and mid-pipeline reset.
module tb_guitar_effect;

  logic        clk;
  logic        rst_n;
  logic        clk_500;
  logic [4:0]  avl_address;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [31:0] avl_readdata;
  logic        avl_read;

  int n_vec  = 0;
  int n_miss = 0;

  guitar_effect dut (
    .clk           (clk),
    .reset         (rst_n),
    .clk_500       (clk_500),
    .avl_address   (avl_address),
    .avl_write     (avl_write),
    .avl_writedata (avl_writedata),
    .avl_readdata  (avl_readdata),
    .avl_read      (avl_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    avl_address   = addr;
    avl_writedata = data;
    avl_write     = 1'b1;
    @(negedge clk);
    avl_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    avl_address = addr;
    #1;
    data = avl_readdata;
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  // One clk_500 rising edge; avl_read must pulse once, 5 negedges later.
  task automatic run_sample(input string tag, input logic [31:0] exp_out);
    int first = 0;
    int pulses = 0;
    @(negedge clk);
    clk_500 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) clk_500 = 1'b0;
      #1;
      if (avl_read) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check({tag, "_latency"}, 32'(first), 32'd5);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    read_check({tag, "_out"}, 5'd5, exp_out);
  endtask

  initial begin
    int pulses;
    rst_n         = 1'b0;
    clk_500       = 1'b0;
    avl_write     = 1'b0;
    avl_address   = '0;
    avl_writedata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    read_check("rst_gain",   5'd1, 32'd1);
    read_check("rst_boost",  5'd2, 32'd1);
    read_check("rst_status", 5'd3, 32'h1);
    read_check("rst_output", 5'd5, 32'd0);
    read_check("rst_input",  5'd6, 32'd0);
    read_check("rst_addr7",  5'd7, 32'd0);
    check("rst_avl_read", 32'(avl_read), 32'd0);

    // Basic path: 10 * 1 * 2
    bus_write(5'd1, 32'd1);
    bus_write(5'd2, 32'd2);
    bus_write(5'd6, 32'd10);
    run_sample("basic", 32'd20);
    bus_write(5'd5, 32'h1234);
    read_check("output_ro", 5'd5, 32'd20);
    bus_write(5'd0, 32'hFFFF_FFFF);
    read_check("addr0", 5'd0, 32'd0);
    read_check("basic_status", 5'd3, 32'h1);

    // INPUT readback is sign-extended, upper write bits dropped
    bus_write(5'd6, 32'hABCD_8001);
    read_check("input_sext", 5'd6, 32'hFFFF_8001);

    // Clip threshold boundary: exactly CLIP_LEVEL does not flag
    bus_write(5'd2, 32'd1);
    bus_write(5'd6, 32'd8192);
    run_sample("clip_eq", 32'd8192);
    read_check("clip_eq_status", 5'd3, 32'h1);
    bus_write(5'd6, 32'd8193);
    run_sample("clip_gt", 32'd8192);
    read_check("clip_gt_status", 5'd3, 32'h3);
    bus_write(5'd3, 32'h3);
    read_check("clip_clear", 5'd3, 32'h1);

    // 20000*4=80000 -> 8192 -> *2 = 16384
    bus_write(5'd1, 32'd4);
    bus_write(5'd2, 32'd2);
    bus_write(5'd6, 32'd20000);
    run_sample("clip", 32'd16384);
    read_check("clip_status", 5'd3, 32'h3);
    bus_write(5'd3, 32'h3);
    read_check("clip_clear2", 5'd3, 32'h1);

    // Saturation both ways: +/-8192*8 = +/-65536
    bus_write(5'd2, 32'd8);
    run_sample("sat_pos", 32'd32767);
    bus_write(5'd6, 32'hFFFF_B1E0);  // -20000
    run_sample("sat_neg", 32'hFFFF_8000);
    bus_write(5'd3, 32'h3);

    // -100 * 3 * 1 = -300
    bus_write(5'd1, 32'd3);
    bus_write(5'd2, 32'd1);
    bus_write(5'd6, 32'hFFFF_FF9C);
    run_sample("neg", 32'hFFFF_FED4);
    read_check("neg_status", 5'd3, 32'h1);

    // GAIN=0 mutes
    bus_write(5'd1, 32'd0);
    run_sample("gain0", 32'd0);

    // Bypass ignores gain/boost and never clips
    bus_write(5'd3, 32'h0);
    bus_write(5'd1, 32'd4);
    bus_write(5'd2, 32'd8);
    bus_write(5'd6, 32'hFFFF_FFFB);
    run_sample("bypass", 32'hFFFF_FFFB);
    bus_write(5'd6, 32'd20000);
    run_sample("bypass_big", 32'd20000);
    read_check("bypass_status", 5'd3, 32'h0);

    // Reset one cycle after the tick discards the in-flight sample
    bus_write(5'd3, 32'h1);
    bus_write(5'd1, 32'd2);
    bus_write(5'd6, 32'd100);
    @(negedge clk);
    clk_500 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n   = 1'b0;
    clk_500 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (avl_read) pulses++;
    end
    check("midrst_pulses", 32'(pulses), 32'd0);
    read_check("midrst_output", 5'd5, 32'd0);
    read_check("midrst_gain",   5'd1, 32'd1);
    read_check("midrst_boost",  5'd2, 32'd1);
    read_check("midrst_input",  5'd6, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
